mul_bus_scheduler: RTL and testbench

//  Shares one bus-attached multiplier between two requesters, round-robin.

---
 rtl/mul_bus_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_mul_bus_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_bus_scheduler.sv
// ============================================================================
//  Module      : mul_bus_scheduler
//  Description : Round-robin arbiter for two requesters sharing one
//                bus-attached multiplier. It runs the load/start/wait/read
//                port sequence and returns the 2N-bit product with the
//                requester id.
//                Optional feature macro: MULSCHED_TIMEOUT_EN (WAIT watchdog).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_bus_scheduler #(
    parameter int N       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic [1:0]       req,
    input  logic [N-1:0]     opa0,
    input  logic [N-1:0]     opb0,
    input  logic [N-1:0]     opa1,
    input  logic [N-1:0]     opb1,
    output logic [1:0]       ack,
    output logic             done,
    output logic             done_id,
    output logic [2*N-1:0]   result,
    output logic             err,
    output logic             mul_start,
    output logic [1:0]       mul_func,
    output logic             mul_oe,
    input  logic             mul_ready,
    inout  wire  [N-1:0]     mul_data
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_M  = 3'd1,
        S_LOAD_Q  = 3'd2,
        S_START   = 3'd3,
        S_WAIT    = 3'd4,
        S_READ_LO = 3'd5,
        S_READ_HI = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [1:0] c_FUNC_LOAD_M  = 2'b00;
    localparam logic [1:0] c_FUNC_LOAD_Q  = 2'b01;
    localparam logic [1:0] c_FUNC_READ_LO = 2'b10;
    localparam logic [1:0] c_FUNC_READ_HI = 2'b11;

    state_t         r_state;
    state_t         w_next;

    logic           r_id;
    logic           r_rr;
    logic [N-1:0]   r_opa;
    logic [N-1:0]   r_opb;
    logic [N-1:0]   r_lo;

    logic           w_grant_valid;
    logic           w_grant_id;
    logic           w_drive;
    logic [N-1:0]   w_drive_data;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_grant_id = 1'b0;
        case (req)
            2'b10:   w_grant_id = 1'b1;
            2'b11:   w_grant_id = ~r_rr;
            default: w_grant_id = 1'b0;
        endcase
    end

    assign w_grant_valid = nreset && (r_state == S_IDLE) && (req != 2'b00);
    assign ack           = w_grant_valid ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;

    assign mul_data = w_drive ? w_drive_data : {N{1'bz}};

`ifdef MULSCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]  r_cnt;
    logic           r_err;
    logic           w_timeout;

    // Fires on the TIMEOUT-th WAIT cycle if the multiplier is still busy.
    assign w_timeout = (r_state == S_WAIT) && !mul_ready && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_grant_valid) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_drive      = 1'b0;
        w_drive_data = r_opa;
        mul_start    = 1'b0;
        mul_func     = c_FUNC_READ_LO;
        mul_oe       = 1'b0;
        done         = 1'b0;
        done_id      = 1'b0;
        err          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    w_next = S_LOAD_M;
                end
            end
            S_LOAD_M: begin
                mul_func     = c_FUNC_LOAD_M;
                w_drive      = 1'b1;
                w_drive_data = r_opa;
                w_next       = S_LOAD_Q;
            end
            S_LOAD_Q: begin
                mul_func     = c_FUNC_LOAD_Q;
                w_drive      = 1'b1;
                w_drive_data = r_opb;
                w_next       = S_START;
            end
            S_START: begin
                mul_start = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (mul_ready) begin
                    w_next = S_READ_LO;
                end
`ifdef MULSCHED_TIMEOUT_EN
                else if (w_timeout) begin
                    w_next = S_DONE;
                end
`endif
            end
            S_READ_LO: begin
                mul_func = c_FUNC_READ_LO;
                mul_oe   = 1'b1;
                w_next   = S_READ_HI;
            end
            S_READ_HI: begin
                mul_func = c_FUNC_READ_HI;
                mul_oe   = 1'b1;
                w_next   = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                done_id = r_id;
`ifdef MULSCHED_TIMEOUT_EN
                err     = r_err;
`endif
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Low half is staged so result only changes as the DONE cycle begins.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_id   <= 1'b0;
            r_rr   <= 1'b1;
            r_opa  <= '0;
            r_opb  <= '0;
            r_lo   <= '0;
            result <= '0;
        end else begin
            if (w_grant_valid) begin
                r_id  <= w_grant_id;
                r_rr  <= w_grant_id;
                r_opa <= w_grant_id ? opa1 : opa0;
                r_opb <= w_grant_id ? opb1 : opb0;
            end
            if (r_state == S_READ_LO) begin
                r_lo <= mul_data;
            end
            if (r_state == S_READ_HI) begin
                result <= {mul_data, r_lo};
            end
`ifdef MULSCHED_TIMEOUT_EN
            if (w_timeout) begin
                result <= '0;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_bus_scheduler.sv
// ============================================================================
//  Module      : tb_mul_bus_scheduler
//  Description : Self-checking bench for mul_bus_scheduler with a bus
//                multiplier model and an arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mul_bus_scheduler;

    logic        clock = 1'b0;
    logic        nreset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [7:0]  opa0 = 8'h00, opb0 = 8'h00, opa1 = 8'h00, opb1 = 8'h00;
    logic [1:0]  ack;
    logic        done, done_id, err, mul_start, mul_oe, mul_ready;
    logic [15:0] result;
    logic [1:0]  mul_func;
    wire  [7:0]  mul_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int viol  = 0;
    int n_done = 0;
    int ack_cyc = -100;
    bit last;

    mul_bus_scheduler dut (
        .clock(clock), .nreset(nreset), .req(req),
        .opa0(opa0), .opb0(opb0), .opa1(opa1), .opb1(opb1),
        .ack(ack), .done(done), .done_id(done_id), .result(result), .err(err),
        .mul_start(mul_start), .mul_func(mul_func), .mul_oe(mul_oe),
        .mul_ready(mul_ready), .mul_data(mul_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Multiplier model: latches M/Q while func selects a load, multiplies on start.
    logic [7:0]  m_m = 8'h00, m_q = 8'h00;
    logic [15:0] m_p = 16'h0000;
    int          m_cnt = 0;
    int          delay = 0;
    bit          stuck = 1'b0;

    always @(posedge clock) begin
        if (mul_func == 2'b00) m_m <= mul_data;
        if (mul_func == 2'b01) m_q <= mul_data;
        if (mul_start) begin
            m_p   <= 16'(m_m) * 16'(m_q);
            m_cnt <= delay;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign mul_ready = !stuck && (m_cnt == 0);
    // Keeper value 5A marks "nobody else on the bus" in read-idle cycles.
    assign mul_data = mul_oe ? (mul_func == 2'b11 ? m_p[15:8] : m_p[7:0])
                             : (mul_func[1] ? 8'h5A : 8'hzz);

    // Protocol observer: load/start phases are tied to the ack cycle.
    always @(negedge clock) begin
        if (nreset) begin
            if (ack != 2'b00) ack_cyc = cyc;
            if (mul_func == 2'b00 && cyc != ack_cyc + 1) viol++;
            if (mul_func == 2'b01 && cyc != ack_cyc + 2) viol++;
            if (mul_start && cyc != ack_cyc + 3) viol++;
            if (mul_oe && !mul_func[1]) viol++;
            if (!mul_func[1] && $isunknown(mul_data)) viol++;
            if (!mul_oe && mul_func[1] && mul_data !== 8'h5A) viol++;
            if (done) n_done++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output logic [1:0] a, output int c);
        a = 2'b00;
        c = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (ack != 2'b00) begin
                a = ack;
                c = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(output logic id, output logic [15:0] r, output logic e, output int c);
        id = 1'bx;
        r  = 16'hxxxx;
        e  = 1'bx;
        c  = -1000;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (done) begin
                id = done_id;
                r  = result;
                e  = err;
                c  = cyc;
                break;
            end
        end
    endtask

    task automatic txn(input string tag, input int id, input logic [7:0] a, input logic [7:0] b,
                       input int dly);
        logic [1:0]  ak;
        logic        did, e;
        logic [15:0] r;
        int          ca, cd;
        delay = dly;
        @(posedge clock); #1;
        if (id == 1) begin opa1 = a; opb1 = b; end
        else begin opa0 = a; opb0 = b; end
        req[id] = 1'b1;
        wait_ack(ak, ca);
        check({tag, "_ack"}, 32'(ak), (id == 1) ? 32'd2 : 32'd1);
        @(posedge clock); #1 req[id] = 1'b0;
        last = (id == 1);
        wait_done(did, r, e, cd);
        check({tag, "_id"}, 32'(did), 32'(id));
        check({tag, "_prod"}, 32'(r), 32'(16'(a) * 16'(b)));
        check({tag, "_err"}, 32'(e), 32'd0);
        check({tag, "_lat"}, 32'(cd - ca), 32'(7 + dly));
    endtask

    initial begin
        logic [1:0]  ak;
        logic        did, e, exp_id;
        logic [15:0] r;
        logic [7:0]  a0, b0, a1, b1;
        int          ca, cd, snap;

        // Reset values
        #2 nreset = 1'b0;
        last = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_func", 32'(mul_func), 32'd2);
        check("rst_oe_start", {30'd0, mul_oe, mul_start}, 32'd0);
        check("rst_bus", 32'(mul_data), 32'h5A);
        @(posedge clock); #1 nreset = 1'b1;

        // Both requesters with FF operands straight after reset
        @(posedge clock); #1;
        opa0 = 8'hFF; opb0 = 8'hFF; opa1 = 8'hFF; opb1 = 8'hFF;
        delay = 0;
        req = 2'b11;
        wait_ack(ak, ca);
        check("both_ack0", 32'(ak), 32'd1);
        @(posedge clock); #1 req[0] = 1'b0;
        wait_done(did, r, e, cd);
        check("both_id0", 32'(did), 32'd0);
        check("both_res0", 32'(r), 32'hFE01);
        wait_ack(ak, ca);
        check("both_ack1", 32'(ak), 32'd2);
        @(posedge clock); #1 req[1] = 1'b0;
        wait_done(did, r, e, cd);
        check("both_id1", 32'(did), 32'd1);
        check("both_res1", 32'(r), 32'hFE01);
        last = 1'b1;

        // Single request, immediate ready
        txn("basic", 0, 8'd12, 8'd13, 0);

        // Both held continuously: grants alternate
        a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        delay = 0;
        @(posedge clock); #1;
        opa0 = a0; opb0 = b0; opa1 = a1; opb1 = b1;
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_id = ~last;
            wait_ack(ak, ca);
            check("alt_ack", 32'(ak), exp_id ? 32'd2 : 32'd1);
            last = exp_id;
            if (g == 3) begin
                @(posedge clock); #1 req = 2'b00;
            end
            wait_done(did, r, e, cd);
            check("alt_id", 32'(did), 32'(exp_id));
            check("alt_res", 32'(r), exp_id ? 32'(16'(a1) * 16'(b1)) : 32'(16'(a0) * 16'(b0)));
            check("alt_lat", 32'(cd - ca), 32'd7);
        end

        // Random operands, ids and ready delays
        for (int i = 0; i < 8; i++) begin
            txn("rand", int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 6)));
        end

        // Ready arrives 20 cycles late
        txn("slow", 1, 8'hA7, 8'h3C, 20);

        // Reset in the middle of WAIT
        stuck = 1'b1;
        @(posedge clock); #1;
        opa1 = 8'h11; opb1 = 8'h22;
        req[1] = 1'b1;
        wait_ack(ak, ca);
        check("mid_ack", 32'(ak), 32'd2);
        @(posedge clock); #1 req[1] = 1'b0;
        repeat (10) @(negedge clock);
        #1 nreset = 1'b0;
        #1;
        check("mid_rst_ctl", {26'd0, ack, done, done_id, err, mul_start}, 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_func", {29'd0, mul_func, mul_oe}, 32'd4);
        check("mid_rst_bus", 32'(mul_data), 32'h5A);
        snap = n_done;
        repeat (3) @(negedge clock);
        @(posedge clock); #1 nreset = 1'b1;
        stuck = 1'b0;
        last = 1'b1;
        repeat (15) @(negedge clock);
        check("mid_no_done", 32'(n_done), 32'(snap));

`ifdef MULSCHED_TIMEOUT_EN
        // Ready stuck low: abort after 64 WAIT cycles
        stuck = 1'b1;
        @(posedge clock); #1;
        opa0 = 8'h55; opb0 = 8'h66;
        req[0] = 1'b1;
        wait_ack(ak, ca);
        check("to_ack", 32'(ak), 32'd1);
        @(posedge clock); #1 req[0] = 1'b0;
        wait_done(did, r, e, cd);
        check("to_err", 32'(e), 32'd1);
        check("to_res", 32'(r), 32'd0);
        check("to_lat", 32'(cd - ca), 32'd68);
        stuck = 1'b0;
        last = 1'b0;
`endif

        // Recovery after reset / abort
        txn("post", 1, 8'hC3, 8'h9E, 2);

        check("protocol_violations", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
